kbd_event_ctrl: RTL

KBD_EVENT_CTRL -- requirements
Module: kbd_event_ctrl

---
 rtl/kbd_event_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/kbd_event_ctrl.sv
// PS/2 scan-code decoder feeding a Wishbone-readable event FIFO with a level interrupt.
// Latency: event lands in the FIFO 2 clocks after its final byte; bus accesses ack 1 clock after strobe.
// Backpressure: none on the code input; a full FIFO drops new events and sets sticky overflow.
// Optional feature: define KBD_REPEAT_FILTER_EN to drop typematic repeats of the last make event.

module kbd_event_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= push_dat;
  end
endmodule

module kbd_event_ctrl #(
  parameter int dw    = 32,
  parameter int aw    = 32,
  parameter int DEPTH = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [aw-1:0] wb_adr_i,
  input  logic [dw-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  output logic [dw-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  input  logic [7:0]    code_i,
  input  logic          code_valid_i,
  output logic          irq_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        state;
  logic          en;
  logic          irq_en;
  logic          overflow;
  logic          ev_vld;
  logic [9:0]    ev_dat;
  logic          ev_ext;
  logic          ev_brk;
  logic          code_drop;
  logic [9:0]    head_dat;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          req;
  logic [1:0]    reg_sel;
  logic          rd_data;
  logic          wr_ctrl;
  logic          wr_stat;
  logic          flush;
  logic          pop;
  logic          push;
  logic [31:0]   rdata;
  logic          unused_bits;

`ifdef KBD_REPEAT_FILTER_EN
  logic          held_vld;
  logic [8:0]    held_dat;
`endif

  // A new access is only taken when no response is outstanding, giving the 2-cycle handshake.
  assign req     = wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o;
  assign reg_sel = wb_adr_i[3:2];
  assign rd_data = req && !wb_we_i && (reg_sel == 2'd0);
  assign wr_stat = req && wb_we_i && (reg_sel == 2'd1) && wb_sel_i[0];
  assign wr_ctrl = req && wb_we_i && (reg_sel == 2'd2) && wb_sel_i[0];
  assign flush   = wr_ctrl && wb_dat_i[2];
  assign pop     = rd_data && !empty;
  assign push    = ev_vld && !flush;

  assign unused_bits = ^{wb_adr_i, wb_dat_i, wb_sel_i};

  assign code_drop = code_i inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF, 8'hE1};
  assign ev_ext    = (state == EXT) || (state == EXT_BRK);
  assign ev_brk    = (state == BRK) || (state == EXT_BRK);

  kbd_event_fifo #(
    .W     (10),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .flush    (flush),
    .push     (push),
    .push_dat (ev_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  always_ff @(posedge wb_clk_i) begin
    ev_vld <= 1'b0;
    if (wb_rst_i) begin
      state  <= IDLE;
      ev_dat <= '0;
`ifdef KBD_REPEAT_FILTER_EN
      held_vld <= 1'b0;
      held_dat <= '0;
`endif
    end else if (flush || !en) begin
      state <= IDLE;
    end else if (code_valid_i && !code_drop) begin
      if (state == IDLE && code_i == 8'hE0) begin
        state <= EXT;
      end else if (state == IDLE && code_i == 8'hF0) begin
        state <= BRK;
      end else if (state == EXT && code_i == 8'hF0) begin
        state <= EXT_BRK;
      end else begin
        state  <= IDLE;
        ev_dat <= {ev_ext, ev_brk, code_i};
`ifdef KBD_REPEAT_FILTER_EN
        if (ev_brk) begin
          held_vld <= 1'b0;
          ev_vld   <= 1'b1;
        end else if (!(held_vld && held_dat == {ev_ext, code_i})) begin
          held_vld <= 1'b1;
          held_dat <= {ev_ext, code_i};
          ev_vld   <= 1'b1;
        end
`else
        ev_vld <= 1'b1;
`endif
      end
    end
  end

  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      2'd0: begin
        if (!empty) rdata = {1'b1, 21'd0, head_dat};
      end
      2'd1: begin
        rdata[0]   = !empty;
        rdata[1]   = full;
        rdata[2]   = overflow;
        rdata[8:4] = 5'(count);
      end
      2'd2: rdata[1:0] = {irq_en, en};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req && (reg_sel != 2'd3);
      wb_err_o <= req && (reg_sel == 2'd3);
      if (req) wb_dat_o <= wb_we_i ? '0 : dw'(rdata);
    end
  end

  // A drop in the same cycle as a software clear wins, so the lost event stays visible.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      en       <= 1'b0;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en     <= wb_dat_i[0];
        irq_en <= wb_dat_i[1];
      end
      if (push && full && !pop)          overflow <= 1'b1;
      else if (wr_stat && wb_dat_i[2])   overflow <= 1'b0;
      irq_o <= irq_en && (!empty || overflow);
    end
  end
endmodule
